load_unit_seq: RTL and testbench

Multi-cycle, parametrised load unit for the RV32I/RV64I core. It succeeds the combinational L-type path and owns the data-memory read handshake. It accepts one load at a time from the execute stage, issues one or two aligned bus reads, extracts and extends the addressed bytes, and returns a single write-back beat for the register file. XLEN generalises the unit to RV64 (LD/LWU), and misaligned accesses spanning a bus word are optionally split.

---
 rtl/load_unit_seq_if.sv | 35 +++
 rtl/load_unit_seq.sv | 172 +++++++++++++++++
 tb/tb_load_unit_seq.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/load_unit_seq_if.sv
// Load unit bus bundle: execute-stage request, data-memory read channel and
// register-file write-back beat. The slave modport is the load unit itself;
// the master modport is the surrounding pipeline/memory environment.
interface load_unit_seq_if #(
   parameter int XLEN   = 32,
   parameter int ADDR_W = 32
);
   // execute-stage request
   logic              ld_valid;
   logic              ld_ready;
   logic [2:0]        funct3;
   logic [ADDR_W-1:0] addr;
   logic [4:0]        rd_idx;
   // data-memory read channel
   logic              mem_req;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_gnt;
   logic              mem_rvalid;
   logic [XLEN-1:0]   mem_rdata;
   // write-back / fault
   logic              wb_valid;
   logic [4:0]        wb_rd;
   logic [XLEN-1:0]   wb_data;
   logic              ld_fault;

   modport slave (
      input  ld_valid, funct3, addr, rd_idx, mem_gnt, mem_rvalid, mem_rdata,
      output ld_ready, mem_req, mem_addr, wb_valid, wb_rd, wb_data, ld_fault
   );

   modport master (
      output ld_valid, funct3, addr, rd_idx, mem_gnt, mem_rvalid, mem_rdata,
      input  ld_ready, mem_req, mem_addr, wb_valid, wb_rd, wb_data, ld_fault
   );
endinterface

// File: rtl/load_unit_seq.sv
// Multi-cycle load unit: accepts one load, issues one or two aligned bus
// reads, extracts/extends the addressed bytes and returns one write-back beat.
// Optional feature macro MISALIGNED_SPLIT_EN: when defined, loads spanning a
// bus word are split into two reads and merged; when undefined they fault.
module load_unit_seq #(
   parameter int XLEN   = 32,
   parameter int ADDR_W = 32
) (
   input logic             clk,
   input logic             reset,
   load_unit_seq_if.slave  bus
);
   localparam int NB   = XLEN / 8;
   localparam int OFFW = $clog2(NB);

   typedef enum logic [2:0] {IDLE, REQ0, WAIT0, REQ1, WAIT1, RESP, FAULT} state_t;

   state_t            state_q;
   logic [2:0]        f3_q;
   logic [OFFW-1:0]   off_q;
   logic [4:0]        rd_q;
   logic              ld_ready_q;
   logic              mem_req_q;
   logic [ADDR_W-1:0] mem_addr_q;
   logic              wb_valid_q;
   logic [4:0]        wb_rd_q;
   logic [XLEN-1:0]   wb_data_q;
   logic              ld_fault_q;
`ifdef MISALIGNED_SPLIT_EN
   logic [XLEN-1:0]   buf0_q;
   logic              mis_q;
`endif

   logic [OFFW-1:0]   in_off;
   logic [7:0]        mis_sum;
   logic              in_mis;
   logic              in_illegal;
   logic [ADDR_W-1:0] in_aligned;

   assign in_off     = bus.addr[OFFW-1:0];
   assign in_aligned = {bus.addr[ADDR_W-1:OFFW], {OFFW{1'b0}}};

   // Decode the incoming request: misalignment and legality
   always_comb begin
      mis_sum    = 8'(in_off) + (8'd1 << bus.funct3[1:0]);
      in_mis     = mis_sum > 8'(NB);
      in_illegal = (bus.funct3 == 3'b111) ||
                   ((XLEN == 32) && ((bus.funct3 == 3'b011) || (bus.funct3 == 3'b110)));
`ifndef MISALIGNED_SPLIT_EN
      in_illegal = in_illegal || in_mis;
`endif
   end

   logic [XLEN-1:0] lo, hi, raw, ext;
   logic            sb, fill;
   int              nbits;

   // Shift the (possibly two-word) read data down to the offset and extend
   always_comb begin
      lo = bus.mem_rdata;
      hi = '0;
`ifdef MISALIGNED_SPLIT_EN
      if (state_q == WAIT1) begin
         lo = buf0_q;
         hi = bus.mem_rdata;
      end
`endif
      raw = XLEN'({hi, lo} >> {off_q, 3'b000});
      case (f3_q[1:0])
         2'd0:    begin nbits = 8;    sb = raw[7];      end
         2'd1:    begin nbits = 16;   sb = raw[15];     end
         2'd2:    begin nbits = 32;   sb = raw[31];     end
         default: begin nbits = XLEN; sb = raw[XLEN-1]; end
      endcase
      // unsigned variants (funct3[2]) zero-fill; LD/RV32 LW fill nothing
      fill = sb & ~f3_q[2];
      ext  = '0;
      for (int i = 0; i < XLEN; i++) ext[i] = (i < nbits) ? raw[i] : fill;
   end

   // Control FSM with registered bus and write-back outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         f3_q       <= '0;
         off_q      <= '0;
         rd_q       <= '0;
         ld_ready_q <= 1'b1;
         mem_req_q  <= 1'b0;
         mem_addr_q <= '0;
         wb_valid_q <= 1'b0;
         wb_rd_q    <= '0;
         wb_data_q  <= '0;
         ld_fault_q <= 1'b0;
`ifdef MISALIGNED_SPLIT_EN
         buf0_q     <= '0;
         mis_q      <= 1'b0;
`endif
      end else begin
         wb_valid_q <= 1'b0;
         ld_fault_q <= 1'b0;
         case (state_q)
            IDLE: if (bus.ld_valid) begin
               f3_q       <= bus.funct3;
               off_q      <= in_off;
               rd_q       <= bus.rd_idx;
               ld_ready_q <= 1'b0;
`ifdef MISALIGNED_SPLIT_EN
               mis_q      <= in_mis;
`endif
               if (in_illegal) begin
                  state_q    <= FAULT;
                  ld_fault_q <= 1'b1;
               end else begin
                  state_q    <= REQ0;
                  mem_req_q  <= 1'b1;
                  mem_addr_q <= in_aligned;
               end
            end
            REQ0: if (bus.mem_gnt) begin
               mem_req_q <= 1'b0;
               state_q   <= WAIT0;
            end
            WAIT0: if (bus.mem_rvalid) begin
`ifdef MISALIGNED_SPLIT_EN
               if (mis_q) begin
                  buf0_q     <= bus.mem_rdata;
                  state_q    <= REQ1;
                  mem_req_q  <= 1'b1;
                  mem_addr_q <= mem_addr_q + ADDR_W'(NB);
               end else
`endif
               begin
                  state_q    <= RESP;
                  wb_valid_q <= 1'b1;
                  wb_rd_q    <= rd_q;
                  wb_data_q  <= ext;
               end
            end
`ifdef MISALIGNED_SPLIT_EN
            REQ1: if (bus.mem_gnt) begin
               mem_req_q <= 1'b0;
               state_q   <= WAIT1;
            end
            WAIT1: if (bus.mem_rvalid) begin
               state_q    <= RESP;
               wb_valid_q <= 1'b1;
               wb_rd_q    <= rd_q;
               wb_data_q  <= ext;
            end
`endif
            RESP, FAULT: begin
               state_q    <= IDLE;
               ld_ready_q <= 1'b1;
            end
            default: begin
               state_q    <= IDLE;
               ld_ready_q <= 1'b1;
               mem_req_q  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.ld_ready = ld_ready_q;
   assign bus.mem_req  = mem_req_q;
   assign bus.mem_addr = mem_addr_q;
   assign bus.wb_valid = wb_valid_q;
   assign bus.wb_rd    = wb_rd_q;
   assign bus.wb_data  = wb_data_q;
   assign bus.ld_fault = ld_fault_q;
endmodule

// File: tb/tb_load_unit_seq.sv
// Bench for load_unit_seq: RV32 and RV64 instances side by side, directed
// loads with a scoreboard of expected write-back/fault beats.
module tb_load_unit_seq;
   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   load_unit_seq_if #(.XLEN(32), .ADDR_W(32)) i32 ();
   load_unit_seq_if #(.XLEN(64), .ADDR_W(32)) i64 ();

   load_unit_seq #(.XLEN(32), .ADDR_W(32)) u32 (.clk(clk), .reset(reset), .bus(i32.slave));
   load_unit_seq #(.XLEN(64), .ADDR_W(32)) u64 (.clk(clk), .reset(reset), .bus(i64.slave));

   int errors = 0;
   int checks = 0;

   typedef struct {
      bit          fault;
      logic [63:0] data;
      logic [4:0]  rd;
      int          cyc;
   } exp_t;
   exp_t sb[$];

   logic        o_req, o_wbv, o_flt, o_rdy;
   logic [31:0] o_addr;
   logic [63:0] o_wd;
   logic [4:0]  o_rd;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic drv(input bit sel, input bit lv, input logic [2:0] f3, input logic [31:0] a,
                      input logic [4:0] rd, input bit g, input bit rv, input logic [63:0] rdata);
      if (sel) begin
         i64.ld_valid = lv; i64.funct3 = f3; i64.addr = a; i64.rd_idx = rd;
         i64.mem_gnt = g; i64.mem_rvalid = rv; i64.mem_rdata = rdata;
      end else begin
         i32.ld_valid = lv; i32.funct3 = f3; i32.addr = a; i32.rd_idx = rd;
         i32.mem_gnt = g; i32.mem_rvalid = rv; i32.mem_rdata = rdata[31:0];
      end
   endtask

   task automatic sample(input bit sel);
      if (sel) begin
         o_req = i64.mem_req; o_addr = i64.mem_addr; o_wbv = i64.wb_valid;
         o_wd = i64.wb_data; o_rd = i64.wb_rd; o_flt = i64.ld_fault; o_rdy = i64.ld_ready;
      end else begin
         o_req = i32.mem_req; o_addr = i32.mem_addr; o_wbv = i32.wb_valid;
         o_wd = 64'(i32.wb_data); o_rd = i32.wb_rd; o_flt = i32.ld_fault; o_rdy = i32.ld_ready;
      end
   endtask

   task automatic chk_reset_vals(input string tag, input bit sel);
      sample(sel);
      chk({tag, ".ready"},   64'(o_rdy),  64'd1);
      chk({tag, ".req"},     64'(o_req),  64'd0);
      chk({tag, ".addr"},    64'(o_addr), 64'd0);
      chk({tag, ".wbv"},     64'(o_wbv),  64'd0);
      chk({tag, ".wbrd"},    64'(o_rd),   64'd0);
      chk({tag, ".wbdata"},  o_wd,        64'd0);
      chk({tag, ".fault"},   64'(o_flt),  64'd0);
   endtask

   // One load: drive request, act as memory (grant after gdly stall cycles,
   // rvalid rvdly cycles after the grant), compare the result beat against the
   // scoreboard entry pushed at issue time. Cycle 0 is the accept cycle.
   task automatic do_load(input string tag, input bit sel, input logic [2:0] f3,
                          input logic [31:0] a, input logic [4:0] rd,
                          input logic [63:0] d0, input logic [63:0] d1,
                          input int gdly, input int rvdly,
                          input bit xf, input logic [63:0] xd, input int xc,
                          input logic [31:0] xa0);
      exp_t e;
      int stall, rvc, k, cyc;
      bit waiting, done;
      @(negedge clk);
      sample(sel);
      chk({tag, ".ready_in"}, 64'(o_rdy), 64'd1);
      chk({tag, ".idle_quiet"}, 64'({o_wbv, o_flt, o_req}), 64'd0);
      drv(sel, 1'b1, f3, a, rd, 1'b0, 1'b0, 64'd0);
      e.fault = xf; e.data = xd; e.rd = rd; e.cyc = xc;
      sb.push_back(e);
      stall = 0; rvc = 0; k = 0; cyc = 0; waiting = 0; done = 0;
      while (!done && cyc < 40) begin
         @(negedge clk);
         cyc++;
         drv(sel, 1'b0, 3'd0, 32'd0, 5'd0, 1'b0, 1'b0, 64'd0);
         sample(sel);
         if (o_wbv || o_flt) begin
            e = sb.pop_front();
            chk({tag, ".kind"}, 64'({o_wbv, o_flt}), e.fault ? 64'd1 : 64'd2);
            chk({tag, ".cycle"}, 64'(cyc), 64'(e.cyc));
            chk({tag, ".no_req"}, 64'(o_req), 64'd0);
            chk({tag, ".busy"}, 64'(o_rdy), 64'd0);
            if (!e.fault) begin
               chk({tag, ".data"}, o_wd, e.data);
               chk({tag, ".rd"}, 64'(o_rd), 64'(e.rd));
            end
            done = 1;
         end else if (o_req) begin
            chk($sformatf("%s.maddr%0d", tag, k), 64'(o_addr),
                64'(xa0 + 32'(k * (sel ? 8 : 4))));
            stall++;
            if (stall > gdly) begin
               drv(sel, 1'b0, 3'd0, 32'd0, 5'd0, 1'b1, 1'b0, 64'd0);
               waiting = 1; rvc = 0; stall = 0;
            end
         end else if (waiting) begin
            if (rvc == rvdly) begin
               drv(sel, 1'b0, 3'd0, 32'd0, 5'd0, 1'b0, 1'b1, (k == 0) ? d0 : d1);
               k++; waiting = 0;
            end else rvc++;
         end
      end
      if (!done) begin
         chk({tag, ".timeout"}, 64'(cyc), 64'(xc));
         sb.delete();
      end
   endtask

   initial begin
      drv(0, 0, 3'd0, 32'd0, 5'd0, 0, 0, 64'd0);
      drv(1, 0, 3'd0, 32'd0, 5'd0, 0, 0, 64'd0);
      reset = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk_reset_vals("rst32", 0);
      chk_reset_vals("rst64", 1);
      reset = 1'b0;

      // byte/half extension, RV32
      do_load("LB",  0, 3'b000, 32'h0010_0002, 5'd1, 64'hF1F2F3F4, 64'd0, 0, 0, 0, 64'hFFFFFFF2, 3, 32'h0010_0000);
      do_load("LBU", 0, 3'b100, 32'h0010_0002, 5'd2, 64'hF1F2F3F4, 64'd0, 0, 0, 0, 64'h000000F2, 3, 32'h0010_0000);
      do_load("LH",  0, 3'b001, 32'h0010_0002, 5'd3, 64'hF1F2F3F4, 64'd0, 0, 0, 0, 64'hFFFFF1F2, 3, 32'h0010_0000);
      do_load("LHU", 0, 3'b101, 32'h0010_0002, 5'd4, 64'hF1F2F3F4, 64'd0, 0, 0, 0, 64'h0000F1F2, 3, 32'h0010_0000);

      // stray rvalid in IDLE must not disturb anything
      @(negedge clk);
      drv(0, 0, 3'd0, 32'd0, 5'd0, 0, 1, 64'hDEADBEEF);
      @(negedge clk);
      drv(0, 0, 3'd0, 32'd0, 5'd0, 0, 0, 64'd0);
      sample(0);
      chk("stray.wbv",   64'(o_wbv), 64'd0);
      chk("stray.data",  o_wd,       64'h0000F1F2);
      chk("stray.rd",    64'(o_rd),  64'd4);
      chk("stray.ready", 64'(o_rdy), 64'd1);
      chk("stray.req",   64'(o_req), 64'd0);

`ifdef MISALIGNED_SPLIT_EN
      do_load("LWsplit", 0, 3'b010, 32'h0010_0003, 5'd5, 64'hF1F2F3F4, 64'h1F2F3F4F, 0, 0, 0, 64'h2F3F4FF1, 5, 32'h0010_0000);
      do_load("LHsplit", 0, 3'b001, 32'h0010_0003, 5'd6, 64'hF1F2F3F4, 64'h1F2F3F4F, 0, 0, 0, 64'h00004FF1, 5, 32'h0010_0000);
`else
      do_load("LWmis", 0, 3'b010, 32'h0010_0003, 5'd5, 64'hF1F2F3F4, 64'h1F2F3F4F, 0, 0, 1, 64'd0, 1, 32'h0010_0000);
      do_load("LHmis", 0, 3'b001, 32'h0010_0003, 5'd6, 64'hF1F2F3F4, 64'h1F2F3F4F, 0, 0, 1, 64'd0, 1, 32'h0010_0000);
`endif
      do_load("LD32", 0, 3'b011, 32'h0010_0000, 5'd7, 64'd0, 64'd0, 0, 0, 1, 64'd0, 1, 32'h0010_0000);

      // grant withheld 3 cycles, rvalid 2 cycles late
      do_load("stall", 0, 3'b010, 32'h0010_0008, 5'd8, 64'h12345678, 64'd0, 3, 2, 0, 64'h12345678, 8, 32'h0010_0008);

      // reset while waiting for read data
      @(negedge clk);
      drv(0, 1, 3'b010, 32'h0010_0010, 5'd9, 0, 0, 64'd0);
      @(negedge clk);
      sample(0);
      chk("rstw.req", 64'(o_req), 64'd1);
      drv(0, 0, 3'd0, 32'd0, 5'd0, 1, 0, 64'd0);
      @(negedge clk);
      drv(0, 0, 3'd0, 32'd0, 5'd0, 0, 0, 64'd0);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk_reset_vals("rstw", 0);
      drv(0, 0, 3'd0, 32'd0, 5'd0, 0, 1, 64'hAAAA5555);
      @(negedge clk);
      drv(0, 0, 3'd0, 32'd0, 5'd0, 0, 0, 64'd0);
      sample(0);
      chk("rstw.late_wbv", 64'(o_wbv), 64'd0);
      chk("rstw.late_rdy", 64'(o_rdy), 64'd1);
      do_load("postrst", 0, 3'b010, 32'h0010_0000, 5'd10, 64'hF1F2F3F4, 64'd0, 0, 0, 0, 64'hF1F2F3F4, 3, 32'h0010_0000);

      // RV64 instance
      do_load("LWU64", 1, 3'b110, 32'h4, 5'd11, 64'h8000000112345678, 64'd0, 0, 0, 0, 64'h0000000080000001, 3, 32'h0);
      do_load("LW64",  1, 3'b010, 32'h4, 5'd12, 64'h8000000112345678, 64'd0, 0, 0, 0, 64'hFFFFFFFF80000001, 3, 32'h0);
      do_load("F111",  1, 3'b111, 32'h0, 5'd13, 64'd0, 64'd0, 0, 0, 1, 64'd0, 1, 32'h0);
      do_load("LD64",  1, 3'b011, 32'h8, 5'd14, 64'h0123456789ABCDEF, 64'd0, 0, 0, 0, 64'h0123456789ABCDEF, 3, 32'h8);
      do_load("LB64",  1, 3'b000, 32'h7, 5'd15, 64'h8000000112345678, 64'd0, 0, 0, 0, 64'hFFFFFFFFFFFFFF80, 3, 32'h0);
`ifdef MISALIGNED_SPLIT_EN
      do_load("LW64s", 1, 3'b010, 32'h6, 5'd16, 64'h8000000112345678, 64'h00000000CAFEBABE, 0, 0, 0, 64'hFFFFFFFFBABE8000, 5, 32'h0);
`else
      do_load("LW64m", 1, 3'b010, 32'h6, 5'd16, 64'h8000000112345678, 64'h00000000CAFEBABE, 0, 0, 1, 64'd0, 1, 32'h0);
`endif

      @(negedge clk);
      sample(1);
      chk("end.ready64", 64'(o_rdy), 64'd1);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
